// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder: bus widths, access
// size encodings, latency bounds and the response-queue entry layout.
package data_sram_responder_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int STRB_W      = DATA_W / 8;
    localparam int SIZE_W      = 2;
    localparam int CNT_W       = 3;
    localparam int QUEUE_DEPTH = 2;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } resp_entry_t;

    // Countdowns park at zero so a waiting head entry stays ready.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// Two-entry in-order response queue. Each entry carries the sampled read data
// and a countdown; the head is ready to retire once its countdown is zero.
module resp_queue
    import data_sram_responder_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              head_ready,
    output logic [DATA_W-1:0] head_data
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

    resp_entry_t slot_q [QUEUE_DEPTH];
    resp_entry_t slot_d [QUEUE_DEPTH];
    resp_entry_t aged   [QUEUE_DEPTH];
    logic [1:0]  level_q;
    logic [1:0]  level_d;
    logic        push_ok;
    logic        pop_ok;
    logic        wr_pos;

    assign full       = (level_q == 2'd2);
    assign empty      = (level_q == 2'd0);
    assign head_ready = (slot_q[0].cnt == '0);
    assign head_data  = slot_q[0].data;
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);

    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            aged[i] = '{data: slot_q[i].data, cnt: cnt_dec(slot_q[i].cnt)};
        end
        slot_d[0] = pop_ok ? aged[1] : aged[0];
        slot_d[1] = aged[1];
        level_d   = level_q;
        // A push lands right behind whatever survives this cycle's pop.
        wr_pos    = pop_ok ? (level_q == 2'd2) : (level_q == 2'd1);

        if (push_ok) begin
            slot_d[wr_pos] = '{data: push_data, cnt: LOAD_CNT};
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 2'd1;
            2'b01:   level_d = level_q - 2'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            level_q <= 2'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Fixed-latency data SRAM responder: word array with byte-lane writes, request
// acceptance, and an in-order response queue that paces data_ok.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [SIZE_W-1:0] data_sram_size,
    input  logic [STRB_W-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [DATA_W-1:0] data_sram_rdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              accept;
    logic              q_full;
    logic              q_empty;
    logic              head_ready;
    logic [DATA_W-1:0] head_data;
    logic              unused_ok;

    // Upper address bits fall away, so out-of-range addresses wrap.
    assign word_idx = data_sram_addr[IDX_W+1:2];

    assign data_sram_data_ok = !rst && !q_empty && head_ready;
    assign data_sram_addr_ok = !rst && (!q_full || data_sram_data_ok);
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign data_sram_rdata   = data_sram_data_ok ? head_data : '0;

    // Lane selection comes from wstrb alone; size is advisory for this array.
    assign unused_ok = ^{data_sram_addr[ADDR_W-1:IDX_W+2], data_sram_addr[1:0], data_sram_size};

    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; its contents survive rst and it maps onto plain RAM.
        if (accept && data_sram_wr) begin
            for (int lane = 0; lane < STRB_W; lane++) begin
                if (data_sram_wstrb[lane]) begin
                    mem[word_idx][8*lane +: 8] <= data_sram_wdata[8*lane +: 8];
                end
            end
        end
    end

    resp_queue #(
        .LATENCY(LATENCY)
    ) u_resp_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (mem[word_idx]),
        .pop       (data_sram_data_ok),
        .full      (q_full),
        .empty     (q_empty),
        .head_ready(head_ready),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances at LATENCY 1, 4 and 3
// share one clock and reset; each test task drives one instance and checks inline.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    logic        clk;
    logic        rst;
    logic        req     [3];
    logic        wr      [3];
    logic [1:0]  size    [3];
    logic [3:0]  strb    [3];
    logic [31:0] addr    [3];
    logic [31:0] wdata   [3];
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata   [3];

    int checks = 0;
    int errors = 0;

    data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
        .data_sram_size(size[0]), .data_sram_wstrb(strb[0]), .data_sram_addr(addr[0]),
        .data_sram_wdata(wdata[0]), .data_sram_addr_ok(addr_ok[0]),
        .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0])
    );

    data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
        .data_sram_size(size[1]), .data_sram_wstrb(strb[1]), .data_sram_addr(addr[1]),
        .data_sram_wdata(wdata[1]), .data_sram_addr_ok(addr_ok[1]),
        .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1])
    );

    data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
        .data_sram_size(size[2]), .data_sram_wstrb(strb[2]), .data_sram_addr(addr[2]),
        .data_sram_wdata(wdata[2]), .data_sram_addr_ok(addr_ok[2]),
        .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int k, input logic r, input logic w, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        req[k]   = r;
        wr[k]    = w;
        size[k]  = sz;
        strb[k]  = st;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 1'b0, SIZE_WORD, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) idle(k);
        drive(0, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h30, 32'h0000_0BAD);
        repeat (2) begin
            @(negedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (addr_ok[k] !== 1'b0) begin errors++; $display("FAIL reset_addr_ok[%0d] got %b exp 0", k, addr_ok[k]); end
                checks++;
                if (data_ok[k] !== 1'b0) begin errors++; $display("FAIL reset_data_ok[%0d] got %b exp 0", k, data_ok[k]); end
                checks++;
                if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d] got %h exp 00000000", k, rdata[k]); end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle(0);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (addr_ok[k] !== 1'b1) begin errors++; $display("FAIL post_reset_addr_ok[%0d] got %b exp 1", k, addr_ok[k]); end
        end
    endtask

    task automatic test_write_read;
        @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h10, 32'hDEAD_BEEF); #1;
        checks++;
        if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL wr_addr_ok got %b exp 1", addr_ok[0]); end
        checks++;
        if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL wr_data_ok_early got %b exp 0", data_ok[0]); end
        @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h10, 32'h0); #1;
        checks++;
        if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL rd_addr_ok got %b exp 1", addr_ok[0]); end
        checks++;
        if (data_ok[0] !== 1'b1) begin errors++; $display("FAIL wr_resp_data_ok got %b exp 1", data_ok[0]); end
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1) begin errors++; $display("FAIL rd_resp_data_ok got %b exp 1", data_ok[0]); end
        checks++;
        if (rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr got %h exp deadbeef", rdata[0]); end
        @(negedge clk); #1;
        checks++;
        if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL wr_rd_quiet got %b exp 0", data_ok[0]); end
    endtask

    task automatic test_partial;
        @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h20, 32'h1122_3344);
        @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_BYTE, 4'b0100, 32'h20, 32'h00AA_0000);
        @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h20, 32'h0);
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h11AA_3344) begin
            errors++; $display("FAIL partial_lane2 got ok=%b %h exp ok=1 11aa3344", data_ok[0], rdata[0]);
        end
        // Size says byte but two strobes are set: both lanes must be written.
        @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_BYTE, 4'b0011, 32'h22, 32'h5566_BEEF);
        @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_BYTE, 4'h0, 32'h23, 32'h0);
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h11AA_BEEF) begin
            errors++; $display("FAIL partial_strb_over_size got ok=%b %h exp ok=1 11aabeef", data_ok[0], rdata[0]);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i)); #1;
            checks++;
            if (addr_ok[0] !== 1'b1) begin errors++; $display("FAIL b2b_wr_addr_ok[%0d] got %b exp 1", i, addr_ok[0]); end
            checks++;
            if (data_ok[0] !== (i > 0)) begin errors++; $display("FAIL b2b_wr_data_ok[%0d] got %b exp %b", i, data_ok[0], (i > 0)); end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h100 + 32'(4*i), 32'h0); #1;
            checks++;
            if (addr_ok[0] !== 1'b1 || data_ok[0] !== 1'b1) begin
                errors++; $display("FAIL b2b_rd_hs[%0d] got addr_ok=%b data_ok=%b exp 1 1", i, addr_ok[0], data_ok[0]);
            end
            if (i > 0) begin
                checks++;
                if (rdata[0] !== 32'hA000_0000 + 32'(i - 1)) begin
                    errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i - 1, rdata[0], 32'hA000_0000 + 32'(i - 1));
                end
            end
        end
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hA000_0007) begin
            errors++; $display("FAIL b2b_last got ok=%b %h exp ok=1 a0000007", data_ok[0], rdata[0]);
        end
        @(negedge clk); #1;
        checks++;
        if (data_ok[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", data_ok[0]); end
    endtask

    task automatic test_wrap;
        @(negedge clk); drive(0, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h1000, 32'h0000_0055);
        @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h0000_0002, 32'h0);
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h0000_0055) begin
            errors++; $display("FAIL wrap got ok=%b %h exp ok=1 00000055", data_ok[0], rdata[0]);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_latency4;
        logic exp_ok  [9];
        logic exp_dok [14];
        int   idx;
        int   nresp;
        exp_ok  = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
        exp_dok = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
        idx = 0;
        for (int c = 0; c < 60 && idx < 5; c++) begin
            @(negedge clk); drive(1, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h200 + 32'(4*idx), 32'hB0 + 32'(idx)); #1;
            if (addr_ok[1] === 1'b1) idx++;
        end
        checks++;
        if (idx != 5) begin errors++; $display("FAIL l4_preload accepted %0d exp 5", idx); end
        @(negedge clk); idle(1);
        repeat (8) @(negedge clk);
        idx   = 0;
        nresp = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (idx < 5) drive(1, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h200 + 32'(4*idx), 32'h0);
            else idle(1);
            #1;
            if (c < 9) begin
                checks++;
                if (addr_ok[1] !== exp_ok[c]) begin errors++; $display("FAIL l4_addr_ok[c%0d] got %b exp %b", c, addr_ok[1], exp_ok[c]); end
            end
            checks++;
            if (data_ok[1] !== exp_dok[c]) begin errors++; $display("FAIL l4_data_ok[c%0d] got %b exp %b", c, data_ok[1], exp_dok[c]); end
            if (exp_dok[c]) begin
                checks++;
                if (rdata[1] !== 32'hB0 + 32'(nresp)) begin
                    errors++; $display("FAIL l4_rdata[%0d] got %h exp %h", nresp, rdata[1], 32'hB0 + 32'(nresp));
                end
                nresp++;
            end
            if (req[1] && addr_ok[1]) idx++;
        end
        idle(1);
    endtask

    task automatic test_reset_mid_flight;
        logic found;
        int   lat;
        @(negedge clk); drive(2, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h40, 32'h1234_5678); #1;
        checks++;
        if (addr_ok[2] !== 1'b1) begin errors++; $display("FAIL mid_preload_addr_ok got %b exp 1", addr_ok[2]); end
        @(negedge clk); idle(2);
        repeat (5) @(negedge clk);
        drive(2, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0); #1;
        checks++;
        if (addr_ok[2] !== 1'b1) begin errors++; $display("FAIL mid_rd0_addr_ok got %b exp 1", addr_ok[2]); end
        @(negedge clk); drive(2, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h44, 32'h0); #1;
        checks++;
        if (addr_ok[2] !== 1'b1) begin errors++; $display("FAIL mid_rd1_addr_ok got %b exp 1", addr_ok[2]); end
        @(negedge clk);
        rst = 1'b1;
        drive(2, 1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h40, 32'h0000_0BAD);
        #1;
        checks++;
        if (addr_ok[2] !== 1'b0 || data_ok[2] !== 1'b0) begin
            errors++; $display("FAIL mid_in_reset got addr_ok=%b data_ok=%b exp 0 0", addr_ok[2], data_ok[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        #1;
        checks++;
        if (addr_ok[2] !== 1'b1) begin errors++; $display("FAIL mid_first_addr_ok got %b exp 1", addr_ok[2]); end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++;
            if (data_ok[2] !== 1'b0) begin errors++; $display("FAIL mid_stale_data_ok[c%0d] got %b exp 0", c, data_ok[2]); end
        end
        @(negedge clk); drive(2, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0); #1;
        checks++;
        if (addr_ok[2] !== 1'b1) begin errors++; $display("FAIL mid_reread_addr_ok got %b exp 1", addr_ok[2]); end
        found = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 10 && !found; c++) begin
            @(negedge clk); idle(2); #1;
            if (data_ok[2] === 1'b1) begin
                found = 1'b1;
                lat   = c;
                checks++;
                if (rdata[2] !== 32'h1234_5678) begin errors++; $display("FAIL mid_array_kept got %h exp 12345678", rdata[2]); end
            end
        end
        checks++;
        if (!found || lat != 3) begin errors++; $display("FAIL mid_reread_latency got found=%b lat=%0d exp 1 3", found, lat); end
        // The LATENCY=1 instance also went through that reset; its earlier write must persist.
        @(negedge clk); drive(0, 1'b1, 1'b0, SIZE_WORD, 4'h0, 32'h10, 32'h0);
        @(negedge clk); idle(0); #1;
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL l1_array_kept got ok=%b %h exp ok=1 deadbeef", data_ok[0], rdata[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_back_to_back();
        test_wrap();
        test_latency4();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
